// File: rtl/axis_pixel_collector.sv
// Show-ahead FIFO that tags upstream pixel words with a round-robin source index
// and presents them as an AXI-stream (tdata/tuser/tlast) with a sticky drop flag.
module axis_pixel_collector #(
    parameter int DEPTH   = 16,
    parameter int NUM_SRC = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                data_in,
    input  logic                       d_valid_in,
    output logic                       p_ready,
    output logic [31:0]                m_tdata,
    output logic [3:0]                 m_tuser,
    output logic                       m_tlast,
    output logic                       m_tvalid,
    input  logic                       m_tready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 37;
    localparam logic [AW:0] FULL_LEVEL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] READY_LEVEL = (AW+1)'(DEPTH - 2);
    localparam logic [3:0]  LAST_SRC    = 4'(NUM_SRC - 1);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    src_idx;
    logic          ovf_q;
    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Handshake: a word leaves on any edge with m_tvalid=1 and m_tready=1; the
    // upstream side has no stall and only sees p_ready, which keeps one slot of
    // margin for the word already in flight when p_ready is sampled low.
    always_comb begin
        pop  = (count != '0) && m_tready;
        push = d_valid_in && ((count != FULL_LEVEL) || pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            src_idx <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + AW'(1);
                src_idx <= (src_idx == LAST_SRC) ? 4'd0 : src_idx + 4'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            // A dropped word leaves src_idx alone so the tag sequence stays dense.
            if (d_valid_in && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {src_idx, (src_idx == LAST_SRC), data_in};
        end
    end

    assign head     = mem[rd_ptr];
    assign m_tdata  = head[31:0];
    assign m_tlast  = head[32];
    assign m_tuser  = head[36:33];
    assign m_tvalid = (count != '0);
    assign level    = count;
    assign overflow = ovf_q;
    assign p_ready  = !rst && (count <= READY_LEVEL);

endmodule
